// File: rtl/sdrc_bist_pkg.sv
// rtl/sdrc_bist_pkg.sv - shared types and constants for the Wishbone BIST engine
package sdrc_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR,
    ST_WR_GAP,
    ST_RD,
    ST_RD_GAP,
    ST_DONE
  } state_e;

  localparam logic [2:0]  CTI_INC   = 3'b010;
  localparam logic [2:0]  CTI_EOB   = 3'b111;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Right-shifting Galois step: the bit shifted out folds the taps back in.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/sdrc_bist_lfsr.sv
// rtl/sdrc_bist_lfsr.sv - 32-bit Galois LFSR pattern source with load and step
module sdrc_bist_lfsr
  import sdrc_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] value_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = SEED;
    else if (step_i) lfsr_d = lfsr_advance(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/sdrc_wb_bist.sv
// rtl/sdrc_wb_bist.sv - Wishbone burst BIST master: writes LFSR bursts, reads back, compares
module sdrc_wb_bist
  import sdrc_bist_pkg::*;
#(
  parameter int              DW         = 32,
  parameter int              AW         = 26,
  parameter int              BURST_LEN  = 8,
  parameter int              NUM_BURSTS = 16,
  parameter logic [AW-1:0]   BASE_ADDR  = '0,
  parameter logic [31:0]     SEED       = 32'hACE1,
  parameter int              TIMEOUT    = 1023
) (
  input  logic              sys_clk,
  input  logic              RESETN,
  input  logic              start,
  input  logic              sdr_init_done,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [AW-1:0]     fail_addr
);

  localparam int            BEAT_W   = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
  localparam int            BURST_W  = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int            TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ADDR_INC = AW'(DW / 8);

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        err_q, err_d;
  logic [AW-1:0]      fail_q, fail_d;
  logic               lfsr_load, lfsr_step;
  logic [31:0]        lfsr_val;
  logic [DW-1:0]      data_word;
  logic               in_burst, last_beat, last_burst;

  sdrc_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i   (sys_clk),
    .rst_n_i (RESETN),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .value_o (lfsr_val)
  );

  // Pattern word is the LFSR value replicated (or truncated) across DW.
  for (genvar i = 0; i < DW; i++) begin : g_word
    assign data_word[i] = lfsr_val[i % 32];
  end

  assign in_burst   = (state_q == ST_WR) || (state_q == ST_RD);
  assign last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_burst = (burst_q == BURST_W'(NUM_BURSTS - 1));

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    fail_d    = fail_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    tmo_d     = (in_burst && !wb_ack_i) ? tmo_q + TMO_W'(1) : '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WAIT_INIT;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = '0;
          fail_d    = '0;
          addr_d    = BASE_ADDR;
          beat_d    = '0;
          burst_d   = '0;
          lfsr_load = 1'b1;
        end
      end
      ST_WAIT_INIT: begin
        if (sdr_init_done) state_d = ST_WR;
      end
      ST_WR, ST_RD: begin
        if (wb_ack_i) begin
          lfsr_step = 1'b1;
          addr_d    = addr_q + ADDR_INC;
          if (state_q == ST_RD && wb_dat_i != data_word) begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if (err_q == '0) fail_d = addr_q;
          end
          if (last_beat) begin
            beat_d  = '0;
            state_d = (state_q == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      ST_WR_GAP: begin
        if (last_burst) begin
          burst_d   = '0;
          addr_d    = BASE_ADDR;
          lfsr_load = 1'b1;
          state_d   = ST_RD;
        end else begin
          burst_d = burst_q + BURST_W'(1);
          state_d = ST_WR;
        end
      end
      ST_RD_GAP: begin
        if (last_burst) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          burst_d = burst_q + BURST_W'(1);
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
    end
  end

  // Bus strobes decode straight from the state register so reset drops them at once.
  assign wb_cyc_o  = in_burst;
  assign wb_stb_o  = in_burst;
  assign wb_we_o   = (state_q == ST_WR);
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = (state_q == ST_WR) ? data_word : '0;
  assign wb_sel_o  = '1;
  assign wb_cti_o  = !in_burst ? 3'b000 : (last_beat ? CTI_EOB : CTI_INC);

  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;
  assign pass      = done_q && (err_q == '0) && !timeout_q;

endmodule

// File: tb/tb_sdrc_wb_bist.sv
// tb/tb_sdrc_wb_bist.sv - scoreboard bench for sdrc_wb_bist with a memory slave model
module tb_sdrc_wb_bist;

  localparam int            DW   = 32;
  localparam int            AW   = 26;
  localparam int            BL   = 8;
  localparam int            NB   = 16;
  localparam int            TMO  = 1023;
  localparam logic [31:0]   SEED = 32'hACE1;
  localparam logic [AW-1:0] BASE = '0;

  logic            sys_clk = 1'b0;
  logic            RESETN;
  logic            start;
  logic            sdr_init_done;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;
  logic            busy, done, pass, timeout;
  logic [15:0]     err_cnt;
  logic [AW-1:0]   fail_addr;

  sdrc_wb_bist #(
    .DW(DW), .AW(AW), .BURST_LEN(BL), .NUM_BURSTS(NB),
    .BASE_ADDR(BASE), .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .sys_clk(sys_clk), .RESETN(RESETN), .start(start), .sdr_init_done(sdr_init_done),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .fail_addr(fail_addr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [2:0]    cti;
  } beat_t;

  beat_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            exp_err;
  logic [AW-1:0] exp_fail;
  logic          exp_fail_set;
  logic [31:0]   mem [int];
  int            ack_mode = 0;   // 0 zero-wait, 1 random 0..5 waits, 2 never ack
  int            wait_cnt = 0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic          prev_cyc = 1'b0;
  logic          seen_burst = 1'b0;
  int            low_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] next_pattern(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  // Whole-pass expectation: every write beat in order, then every read beat in order.
  task automatic build_expected();
    beat_t       b;
    logic [31:0] v;
    exp_q.delete();
    for (int ph = 0; ph < 2; ph++) begin
      v = SEED;
      for (int i = 0; i < NB * BL; i++) begin
        b.we   = (ph == 0);
        b.addr = BASE + AW'(i * (DW / 8));
        b.data = v;
        b.cti  = ((i % BL) == BL - 1) ? 3'b111 : 3'b010;
        exp_q.push_back(b);
        v = next_pattern(v);
      end
    end
    exp_err      = 0;
    exp_fail     = '0;
    exp_fail_set = 1'b0;
    wait_cnt     = 0;
  endtask

  // Slave: decides ack just after each rising edge so the DUT samples it at the next one.
  always begin
    logic [31:0] d;
    @(posedge sys_clk);
    #1;
    if (wb_cyc_o && wb_stb_o && ack_mode != 2) begin
      if (wait_cnt == 0) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          mem[int'(wb_addr_o)] = wb_dat_o;
        end else begin
          d = mem.exists(int'(wb_addr_o)) ? mem[int'(wb_addr_o)] : 32'hDEADBEEF;
          if (corrupt_en && wb_addr_o == corrupt_addr) d = d ^ 32'h0000_0100;
          wb_dat_i = d;
        end
        wait_cnt = (ack_mode == 1) ? int'($urandom_range(5, 0)) : 0;
      end else begin
        wb_ack_i = 1'b0;
        wait_cnt--;
      end
    end else begin
      wb_ack_i = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every acked beat and checks bus framing.
  always @(negedge sys_clk) begin
    beat_t e;
    if (!busy) seen_burst = 1'b0;
    if (wb_cyc_o) begin
      check("cyc_needs_init", sdr_init_done, 1);
      check("stb_eq_cyc", wb_stb_o, 1);
      check("sel_all_ones", wb_sel_o, 4'hF);
      if (!prev_cyc && seen_burst) check("gap_len", low_run, 1);
      seen_burst = 1'b1;
      low_run    = 0;
    end else begin
      low_run++;
    end
    prev_cyc = wb_cyc_o;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr 0x%0h expected no beat", wb_addr_o);
      end else begin
        e = exp_q.pop_front();
        check("beat_we", wb_we_o, e.we);
        check("beat_addr", wb_addr_o, e.addr);
        check("beat_cti", wb_cti_o, e.cti);
        if (e.we) begin
          check("beat_wdata", wb_dat_o, e.data);
        end else if (wb_dat_i !== e.data) begin
          exp_err++;
          if (!exp_fail_set) begin
            exp_fail     = e.addr;
            exp_fail_set = 1'b1;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40000; i++) begin
      @(negedge sys_clk);
      if (done) break;
    end
    check("done_reached", done, 1);
  endtask

  task automatic check_final(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_cnt"}, err_cnt, 64'(exp_err));
    check({tag, "_fail_addr"}, fail_addr, exp_fail);
    check({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
    check({tag, "_beats_left"}, exp_q.size(), 0);
  endtask

  task automatic run_pass(input string tag);
    build_expected();
    pulse_start();
    wait_done();
    check_final(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, wb_cyc_o, 0);
    check({tag, "_stb"}, wb_stb_o, 0);
    check({tag, "_we"}, wb_we_o, 0);
    check({tag, "_addr"}, wb_addr_o, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_seen;
    int stb_run;
    int rd_acks;
    RESETN        = 1'b0;
    start         = 1'b0;
    sdr_init_done = 1'b0;
    wb_ack_i      = 1'b0;
    wb_dat_i      = '0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    check("reset_dat", wb_dat_o, 0);
    check("reset_cti", wb_cti_o, 0);
    @(negedge sys_clk);
    RESETN = 1'b1;

    // Start before SDRAM init: no bus activity until init completes.
    build_expected();
    pulse_start();
    @(negedge sys_clk);
    check("wait_init_busy", busy, 1);
    cyc_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (wb_cyc_o) cyc_seen++;
    end
    check("no_cyc_before_init", cyc_seen, 0);
    sdr_init_done = 1'b1;
    wait_done();
    check_final("zero_wait");
    check("zero_wait_pass_const", pass, 1);

    // Random slave wait states; a second start mid-pass must be ignored.
    ack_mode = 1;
    build_expected();
    pulse_start();
    repeat (50) @(negedge sys_clk);
    pulse_start();
    wait_done();
    check_final("rand_wait");

    // Single corrupted read word.
    corrupt_en   = 1'b1;
    corrupt_addr = AW'(32'h24);
    run_pass("corrupt");
    check("corrupt_err_const", err_cnt, 1);
    check("corrupt_fail_const", fail_addr, 26'h24);
    check("corrupt_pass_const", pass, 0);
    corrupt_en = 1'b0;

    // Slave never acknowledges.
    ack_mode = 2;
    build_expected();
    pulse_start();
    for (int i = 0; i < 200 && !wb_stb_o; i++) @(negedge sys_clk);
    stb_run = 0;
    while (wb_stb_o && stb_run < 3000) begin
      stb_run++;
      @(negedge sys_clk);
    end
    check("timeout_stb_cycles", stb_run, TMO);
    check("timeout_flag", timeout, 1);
    check("timeout_done", done, 1);
    check("timeout_pass", pass, 0);
    check("timeout_cyc", wb_cyc_o, 0);
    check("timeout_busy", busy, 0);

    // Asynchronous reset in the middle of a read burst.
    ack_mode = 1;
    build_expected();
    pulse_start();
    rd_acks = 0;
    for (int i = 0; i < 20000 && rd_acks < 20; i++) begin
      @(negedge sys_clk);
      if (wb_cyc_o && !wb_we_o && wb_ack_i) rd_acks++;
    end
    check("reached_read_phase", rd_acks, 20);
    @(posedge sys_clk);
    #2 RESETN = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge sys_clk);
    RESETN = 1'b1;
    ack_mode = 0;
    run_pass("after_reset");
    check("after_reset_pass_const", pass, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
